dma_copy_engine: RTL and testbench

- Memory-to-memory copy engine; a third bus master beside the FFT and crypto accelerators.
- CPU programs it via a register slave port behind the SoC interconnect.
- It moves words through the accelerator memory arbiter into/out of RAM, so the CPU can stage FFT/crypto buffers without a software copy loop.
- Single outstanding memory transaction; one word buffered between read and write.

---
 rtl/dma_copy_engine.sv | 193 +++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - memory-to-memory copy engine with register slave port
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   bus_valid/bus_write/bus_addr  register access strobe, direction, address (bits [2:0] decoded)
//   bus_wdata, bus_rdata          register write data, registered read data
//   mem_valid/mem_write/mem_addr  memory request to the arbiter
//   mem_wdata, mem_rdata          memory write data, read data (valid the cycle after read grant)
//   mem_gnt                       arbiter accepted the current request
//   irq                           level interrupt, mirrors STATUS.done
module dma_copy_engine #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 19,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_gnt,
    output logic              irq
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_SRC    = 3'd1;
    localparam logic [2:0] REG_DST    = 3'd2;
    localparam logic [2:0] REG_LEN    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_REMAIN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [ADDR_W-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic [LEN_W-1:0]  remain;
    logic              done_q;
    logic              aborted_q;
    logic              abort_pend;

    logic [2:0] sel;
    logic       reg_wr;
    logic       busy;
    logic       ctrl_start;
    logic       ctrl_abort;

    assign sel        = bus_addr[2:0];
    assign reg_wr     = bus_valid && bus_write;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    // Abort outranks start when both bits are written together.
    assign ctrl_abort = reg_wr && (sel == REG_CTRL) && bus_wdata[1];
    assign ctrl_start = reg_wr && (sel == REG_CTRL) && bus_wdata[0] && !bus_wdata[1];
    assign irq        = done_q;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus_addr[ADDR_W-1:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            len_reg    <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            remain     <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abort_pend <= 1'b0;
            bus_rdata  <= '0;
            mem_valid  <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (bus_valid && !bus_write) begin
                case (sel)
                    REG_SRC:    bus_rdata <= DATA_W'(src_reg);
                    REG_DST:    bus_rdata <= DATA_W'(dst_reg);
                    REG_LEN:    bus_rdata <= DATA_W'(len_reg);
                    REG_STATUS: bus_rdata <= DATA_W'({aborted_q, done_q, busy});
                    REG_REMAIN: bus_rdata <= DATA_W'(remain);
                    default:    bus_rdata <= '0;
                endcase
            end

            if (reg_wr && !busy) begin
                case (sel)
                    REG_SRC: src_reg <= ADDR_W'(bus_wdata);
                    REG_DST: dst_reg <= ADDR_W'(bus_wdata);
                    REG_LEN: len_reg <= LEN_W'(bus_wdata);
                    default: ;
                endcase
            end

            // Write-one-to-clear; the FSM below may set done again in the same cycle and wins.
            if (reg_wr && (sel == REG_STATUS)) begin
                if (bus_wdata[1]) done_q    <= 1'b0;
                if (bus_wdata[2]) aborted_q <= 1'b0;
            end

            case (state)
                S_IDLE: ;
                S_RD_REQ: begin
                    if (ctrl_abort) begin
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (mem_gnt) begin
                        state     <= S_RD_WAIT;
                        mem_valid <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (ctrl_abort) begin
                        state     <= S_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        // mem_wdata doubles as the single-word buffer between read and write.
                        mem_wdata <= mem_rdata;
                        mem_valid <= 1'b1;
                        mem_write <= 1'b1;
                        mem_addr  <= cur_dst;
                        state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    // An abort here waits for the pending write so no word is left half-copied.
                    if (ctrl_abort) abort_pend <= 1'b1;
                    if (mem_gnt) begin
                        cur_src    <= cur_src + ADDR_W'(1);
                        cur_dst    <= cur_dst + ADDR_W'(1);
                        remain     <= remain - LEN_W'(1);
                        abort_pend <= 1'b0;
                        if (remain == LEN_W'(1)) begin
                            state     <= S_DONE;
                            mem_valid <= 1'b0;
                        end else if (abort_pend || ctrl_abort) begin
                            state     <= S_IDLE;
                            mem_valid <= 1'b0;
                            aborted_q <= 1'b1;
                        end else begin
                            state     <= S_RD_REQ;
                            mem_valid <= 1'b1;
                            mem_write <= 1'b0;
                            mem_addr  <= cur_src + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (ctrl_start && !busy) begin
                cur_src    <= src_reg;
                cur_dst    <= dst_reg;
                remain     <= len_reg;
                done_q     <= 1'b0;
                aborted_q  <= 1'b0;
                abort_pend <= 1'b0;
                if (len_reg == '0) begin
                    state <= S_DONE;
                end else begin
                    state     <= S_RD_REQ;
                    mem_valid <= 1'b1;
                    mem_write <= 1'b0;
                    mem_addr  <= src_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - directed self-checking bench for dma_copy_engine
module tb_dma_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        bus_valid;
    logic        bus_write;
    logic [18:0] bus_addr;
    logic [18:0] bus_wdata;
    logic [18:0] bus_rdata;
    logic        mem_valid;
    logic        mem_write;
    logic [18:0] mem_addr;
    logic [18:0] mem_wdata;
    logic [18:0] mem_rdata;
    logic        mem_gnt;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    dma_copy_engine #(.ADDR_W(19), .DATA_W(19), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_valid (bus_valid),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_gnt   (mem_gnt),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: untouched words hold a fixed address-derived pattern.
    logic [18:0] ram [logic [18:0]];
    logic [18:0] rd_log [$];
    int          valid_cycles = 0;

    function automatic logic [18:0] pat(input logic [18:0] a);
        return {a[9:0], a[18:10]} ^ 19'h2A5A5;
    endfunction

    function automatic logic [18:0] mem_val(input logic [18:0] a);
        return ram.exists(a) ? ram[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (mem_valid) valid_cycles++;
        if (mem_valid && mem_gnt) begin
            if (mem_write) ram[mem_addr] = mem_wdata;
            else begin
                rd_log.push_back(mem_addr);
                mem_rdata <= mem_val(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [18:0] d);
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_addr  = {16'h0, a};
        bus_wdata = d;
        @(negedge clk);
        bus_valid = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [18:0] d);
        bus_valid = 1'b1;
        bus_write = 1'b0;
        bus_addr  = {16'h0, a};
        @(negedge clk);
        bus_valid = 1'b0;
        d = bus_rdata;
    endtask

    task automatic program_xfer(input logic [18:0] s, input logic [18:0] d, input logic [18:0] n);
        reg_wr(3'd1, s);
        reg_wr(3'd2, d);
        reg_wr(3'd3, n);
    endtask

    task automatic wait_irq(input string tag, input int max);
        int n = 0;
        while (!irq && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(irq), 32'd1);
    endtask

    task automatic wait_wr(input logic [18:0] a, input string tag);
        int  n = 0;
        logic found = 1'b0;
        while (n < 100) begin
            if (mem_valid && mem_write && mem_addr == a) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [18:0] rd;
        logic [18:0] held_addr;
        logic [18:0] held_data;
        int          vc;
        int          n0;

        rst_n = 1'b0; bus_valid = 1'b0; bus_write = 1'b0;
        bus_addr = '0; bus_wdata = '0; mem_gnt = 1'b1; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_mem_valid", 32'(mem_valid), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_rdata", 32'(bus_rdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        reg_rd(3'd4, rd);
        chk("reset_status", 32'(rd), 32'd0);

        // Register readback details
        reg_wr(3'd3, 19'h7FFFF);
        reg_rd(3'd3, rd);
        chk("len_upper_zero", 32'(rd), 32'h0FFFF);
        reg_rd(3'd6, rd);
        chk("unmapped_read", 32'(rd), 32'd0);

        // Basic copy of 4 words, done exactly 13 cycles after the start write
        program_xfer(19'h00100, 19'h00200, 19'd4);
        reg_wr(3'd0, 19'd1);
        repeat (12) @(negedge clk);
        chk("len4_irq_before", 32'(irq), 32'd0);
        @(negedge clk);
        chk("len4_irq_at13", 32'(irq), 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("len4_data%0d", i), 32'(mem_val(19'h00200 + 19'(i))), 32'(pat(19'h00100 + 19'(i))));
        reg_rd(3'd4, rd);
        chk("len4_status", 32'(rd), 32'b010);
        reg_wr(3'd4, 19'd2);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Zero-length transfer
        reg_wr(3'd3, 19'd0);
        vc = valid_cycles;
        reg_wr(3'd0, 19'd1);
        chk("len0_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        chk("len0_irq", 32'(irq), 32'd1);
        chk("len0_no_traffic", 32'(valid_cycles - vc), 32'd0);

        // Grant stall during second write keeps the request stable
        program_xfer(19'h00120, 19'h00220, 19'd3);
        reg_wr(3'd0, 19'd1);
        wait_wr(19'h00221, "stall_found");
        mem_gnt = 1'b0;
        held_addr = mem_addr;
        held_data = mem_wdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", i),
                32'({mem_valid, mem_write, mem_addr == held_addr, mem_wdata == held_data}), 32'hF);
        end
        mem_gnt = 1'b1;
        wait_irq("stall_done", 50);
        for (int i = 0; i < 3; i++)
            chk($sformatf("stall_data%0d", i), 32'(mem_val(19'h00220 + 19'(i))), 32'(pat(19'h00120 + 19'(i))));
        reg_rd(3'd5, rd);
        chk("stall_remain0", 32'(rd), 32'd0);

        // Source address wraps around the top of memory
        program_xfer(19'h7FFFE, 19'h00300, 19'd3);
        n0 = rd_log.size();
        reg_wr(3'd0, 19'd1);
        wait_irq("wrap_done", 50);
        chk("wrap_rd0", 32'(rd_log[n0]), 32'h7FFFE);
        chk("wrap_rd1", 32'(rd_log[n0 + 1]), 32'h7FFFF);
        chk("wrap_rd2", 32'(rd_log[n0 + 2]), 32'h00000);
        chk("wrap_data2", 32'(mem_val(19'h00302)), 32'(pat(19'h00000)));

        // Abort arriving during word-3 write: that write finishes, nothing after it
        program_xfer(19'h00400, 19'h00500, 19'd8);
        reg_wr(3'd0, 19'd1);
        wait_wr(19'h00502, "abort_found");
        mem_gnt = 1'b0;
        reg_wr(3'd0, 19'd2);
        chk("abort_write_pending", 32'({mem_valid, mem_write}), 32'b11);
        mem_gnt = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_word3", 32'(mem_val(19'h00502)), 32'(pat(19'h00402)));
        for (int i = 3; i < 8; i++)
            chk($sformatf("abort_untouched%0d", i), 32'(mem_val(19'h00500 + 19'(i))), 32'(pat(19'h00500 + 19'(i))));
        reg_rd(3'd4, rd);
        chk("abort_status", 32'(rd), 32'b100);
        reg_rd(3'd5, rd);
        chk("abort_remain", 32'(rd), 32'd5);
        chk("abort_irq", 32'(irq), 32'd0);

        // Start and abort together: abort wins, no transfer
        reg_wr(3'd4, 19'd6);
        reg_wr(3'd3, 19'd4);
        vc = valid_cycles;
        reg_wr(3'd0, 19'd3);
        repeat (3) @(negedge clk);
        reg_rd(3'd4, rd);
        chk("start_abort_status", 32'(rd), 32'd0);
        chk("start_abort_no_traffic", 32'(valid_cycles - vc), 32'd0);

        // Reset mid-transfer, then a fresh transfer with a write to SRC while busy
        program_xfer(19'h00640, 19'h00740, 19'd8);
        reg_wr(3'd0, 19'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs",
            32'({mem_valid, mem_write, irq, |mem_addr, |mem_wdata, |bus_rdata}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_kept_word0", 32'(mem_val(19'h00740)), 32'(pat(19'h00640)));
        reg_rd(3'd1, rd);
        chk("rst_src_cleared", 32'(rd), 32'd0);
        program_xfer(19'h00600, 19'h00700, 19'd2);
        reg_wr(3'd0, 19'd1);
        reg_wr(3'd1, 19'h00123);
        reg_rd(3'd1, rd);
        chk("busy_src_ignored", 32'(rd), 32'h00600);
        wait_irq("post_rst_done", 50);
        for (int i = 0; i < 2; i++)
            chk($sformatf("post_rst_data%0d", i), 32'(mem_val(19'h00700 + 19'(i))), 32'(pat(19'h00600 + 19'(i))));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
